wb_trace_fifo: RTL and testbench

WB_TRACE_FIFO -- requirements
Module: wb_trace_fifo

---
 rtl/wb_trace_fifo.sv | 92 +++++++++
 tb/tb_wb_trace_fifo.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_trace_fifo.sv
// Trace FIFO for CPU register-file and data-memory writes, first-word-fall-through.
// A GRF write wins over a same-cycle DM write; dropped events set a sticky overflow flag.
module wb_trace_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          grf_we,
  input  logic [4:0]    grf_addr,
  input  logic [31:0]   grf_wd,
  input  logic          dm_we,
  input  logic [31:0]   dm_addr,
  input  logic [31:0]   dm_wd,
  input  logic [31:0]   pc,
  input  logic          clr,
  input  logic          out_ready,
  output logic          out_valid,
  output logic          out_type,
  output logic [31:0]   out_pc,
  output logic [31:0]   out_addr,
  output logic [31:0]   out_data,
  output logic [AW:0]   count,
  output logic          overflow
);

  localparam logic [AW:0] LP_FULL = (AW+1)'(DEPTH);

  logic          r_type_mem [DEPTH];
  logic [31:0]   r_pc_mem   [DEPTH];
  logic [31:0]   r_addr_mem [DEPTH];
  logic [31:0]   r_data_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count;
  logic          r_overflow;

  logic        w_grf_ev, w_dm_ev, w_push_req, w_full, w_pop, w_push, w_drop;
  logic        w_in_type;
  logic [31:0] w_in_addr, w_in_data;

  assign w_grf_ev   = grf_we && (grf_addr != 5'd0);
  assign w_dm_ev    = dm_we;
  assign w_push_req = w_grf_ev || w_dm_ev;
  assign w_full     = (r_count == LP_FULL);
  assign w_pop      = (r_count != '0) && out_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_drop     = (w_grf_ev && w_dm_ev) || (w_push_req && !w_push);

  assign w_in_type  = !w_grf_ev;
  assign w_in_addr  = w_grf_ev ? {27'd0, grf_addr} : dm_addr;
  assign w_in_data  = w_grf_ev ? grf_wd : dm_wd;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (clr) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  // Storage is not reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (w_push && !clr && reset) begin
      r_type_mem[r_wptr] <= w_in_type;
      r_pc_mem[r_wptr]   <= pc;
      r_addr_mem[r_wptr] <= w_in_addr;
      r_data_mem[r_wptr] <= w_in_data;
    end
  end

  assign out_valid = (r_count != '0);
  assign out_type  = r_type_mem[r_rptr];
  assign out_pc    = r_pc_mem[r_rptr];
  assign out_addr  = r_addr_mem[r_rptr];
  assign out_data  = r_data_mem[r_rptr];
  assign count     = r_count;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_wb_trace_fifo.sv
// Directed bench for wb_trace_fifo: queue-based reference model checked every cycle,
// plus literal expectations for the scenarios of interest.
module tb_wb_trace_fifo;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        grf_we, dm_we, clr, out_ready;
  logic [4:0]  grf_addr;
  logic [31:0] grf_wd, dm_addr, dm_wd, pc;
  logic        out_valid, out_type, overflow;
  logic [31:0] out_pc, out_addr, out_data;
  logic [AW:0] count;

  int checks = 0;
  int errs   = 0;

  typedef struct packed {
    logic        t;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
  } ent_t;

  ent_t q[$];
  logic m_ovf;

  wb_trace_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .grf_we(grf_we), .grf_addr(grf_addr), .grf_wd(grf_wd),
    .dm_we(dm_we), .dm_addr(dm_addr), .dm_wd(dm_wd), .pc(pc),
    .clr(clr), .out_ready(out_ready),
    .out_valid(out_valid), .out_type(out_type), .out_pc(out_pc),
    .out_addr(out_addr), .out_data(out_data), .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue plus a sticky flag, updated from the input rules.
  initial forever begin
    @(negedge reset);
    q.delete();
    m_ovf = 1'b0;
  end

  initial forever begin
    @(posedge clk);
    if (reset === 1'b1) begin
      if (clr) begin
        q.delete();
        m_ovf = 1'b0;
      end else begin
        bit g, d, pop, was_full;
        ent_t e;
        g = grf_we && (grf_addr != 0);
        d = dm_we;
        was_full = (q.size() == DEPTH);
        pop = (q.size() != 0) && out_ready;
        if (g && d) m_ovf = 1'b1;
        if (g) e = '{t: 1'b0, pc: pc, addr: {27'd0, grf_addr}, data: grf_wd};
        else   e = '{t: 1'b1, pc: pc, addr: dm_addr, data: dm_wd};
        if (pop) void'(q.pop_front());
        if (g || d) begin
          if (was_full && !pop) m_ovf = 1'b1;
          else q.push_back(e);
        end
      end
    end
  end

  // Single compare process, mid-cycle.
  always @(negedge clk) begin
    chk("count", 32'(count), 32'(q.size()));
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    if (q.size() != 0) begin
      chk("head_type", 32'(out_type), 32'(q[0].t));
      chk("head_pc", out_pc, q[0].pc);
      chk("head_addr", out_addr, q[0].addr);
      chk("head_data", out_data, q[0].data);
    end
  end

  task automatic idle();
    grf_we = 0; dm_we = 0; clr = 0;
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic do_clr();
    clr = 1; cyc(); clr = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 0; idle(); out_ready = 0;
    grf_addr = 0; grf_wd = 0; dm_addr = 0; dm_wd = 0; pc = 0;
    cyc(); cyc();
    chk("rst_count", 32'(count), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_ovf", 32'(overflow), 0);
    reset = 1;
    cyc();

    // Push and first-word-fall-through latency
    grf_we = 1; grf_addr = 5; grf_wd = 32'h12345678; pc = 32'h3000; out_ready = 0;
    cyc(); idle();
    chk("lat_valid", 32'(out_valid), 1);
    chk("lat_type", 32'(out_type), 0);
    chk("lat_addr", out_addr, 5);
    chk("lat_data", out_data, 32'h12345678);
    chk("lat_pc", out_pc, 32'h3000);
    chk("lat_count", 32'(count), 1);
    out_ready = 1; cyc(); out_ready = 0;
    chk("drain1_count", 32'(count), 0);

    // Writes to $0 are filtered
    grf_we = 1; grf_addr = 0;
    repeat (3) cyc();
    idle();
    chk("zero_count", 32'(count), 0);
    chk("zero_valid", 32'(out_valid), 0);

    // Overflow on the ninth DM push
    for (int i = 0; i < 9; i++) begin
      dm_we = 1; dm_addr = 32'(4*i); dm_wd = 32'(i); pc = 32'h4000 + 32'(4*i);
      cyc();
    end
    idle();
    chk("ovf_count", 32'(count), 8);
    chk("ovf_flag", 32'(overflow), 1);
    out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      chk("drain_addr", out_addr, 32'(4*i));
      cyc();
    end
    out_ready = 0;
    chk("drain_empty", 32'(out_valid), 0);
    chk("ovf_sticky", 32'(overflow), 1);
    do_clr();
    chk("clr_ovf", 32'(overflow), 0);

    // Full with simultaneous pop keeps count at DEPTH, no overflow
    for (int i = 0; i < 8; i++) begin
      grf_we = 1; grf_addr = 5'(i+1); grf_wd = 32'hA0 + 32'(i); pc = 32'(i);
      cyc();
    end
    grf_addr = 5'd20; grf_wd = 32'hBB; out_ready = 1;
    cyc(); idle(); out_ready = 0;
    chk("fullpop_count", 32'(count), 8);
    chk("fullpop_ovf", 32'(overflow), 0);
    chk("fullpop_head", out_data, 32'hA1);
    do_clr();
    chk("clr2_count", 32'(count), 0);

    // Wrap with concurrent push/pop, alternating GRF/DM
    out_ready = 1;
    for (int i = 0; i < 20; i++) begin
      idle();
      if (i % 2 == 0) begin
        grf_we = 1; grf_addr = 5'((i % 31) + 1); grf_wd = 32'(i);
      end else begin
        dm_we = 1; dm_addr = 32'h100 + 32'(i); dm_wd = 32'(i);
      end
      pc = 32'h8000 + 32'(i);
      cyc();
      chk("wrap_le1", 32'(count <= 1), 1);
      chk("wrap_head", out_data, 32'(i));
    end
    idle(); cyc(); out_ready = 0;
    chk("wrap_empty", 32'(count), 0);
    chk("wrap_ovf", 32'(overflow), 0);

    // Simultaneous GRF and DM strobes
    grf_we = 1; grf_addr = 3; grf_wd = 32'hCAFE; dm_we = 1; dm_addr = 32'h40; dm_wd = 32'hBEEF;
    cyc(); idle();
    chk("sim_count", 32'(count), 1);
    chk("sim_ovf", 32'(overflow), 1);
    chk("sim_type", 32'(out_type), 0);
    chk("sim_data", out_data, 32'hCAFE);
    do_clr();
    chk("sim_clr_count", 32'(count), 0);
    chk("sim_clr_ovf", 32'(overflow), 0);

    // Mid-operation asynchronous reset
    for (int i = 0; i < 5; i++) begin
      grf_we = 1; grf_addr = 5'(i+1); grf_wd = 32'(i); cyc();
    end
    idle();
    chk("pre_rst_count", 32'(count), 5);
    #2 reset = 0;
    #1;
    chk("async_valid", 32'(out_valid), 0);
    chk("async_count", 32'(count), 0);
    grf_we = 1; grf_addr = 9;
    cyc(); idle();
    chk("rst_ignore", 32'(count), 0);
    reset = 1;
    grf_we = 1; grf_addr = 7; grf_wd = 32'h77; pc = 32'h9000;
    cyc(); idle();
    chk("post_rst_valid", 32'(out_valid), 1);
    chk("post_rst_addr", out_addr, 7);
    chk("post_rst_count", 32'(count), 1);
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errs);
    $finish;
  end
endmodule
